// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo
// Description : PS/2 device-to-host receiver with scan-code FIFO.
//               Synchronises and deglitches the raw PS/2 clock and data
//               lines, deserialises 11-bit frames (start, 8 data LSB-first,
//               odd parity, stop), validates them and buffers accepted bytes
//               in a FIFO read through a ready/read-ack handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FILTER_LEN      consecutive equal samples needed to accept a clock change
//   TIMEOUT_CYCLES  clk cycles without a falling edge that abort a frame
//   FIFO_AW         FIFO address width, depth = 2**FIFO_AW bytes
// Ports
//   clk            in   system clock
//   reset          in   synchronous active-high reset
//   ps2_clk_i      in   raw PS/2 clock (asynchronous)
//   ps2_data_i     in   raw PS/2 data (asynchronous)
//   rx_scan_code   out  last popped scan code (registered)
//   rx_data_ready  out  FIFO non-empty (registered)
//   rx_read        in   pop request, one clk per byte
//   rx_overflow    out  1-cycle pulse, valid frame dropped on full FIFO
//   rx_frame_err   out  1-cycle pulse, frame rejected
// Configuration macro
//   PS2_PARITY_CHECK_EN  when defined, odd-parity failures reject the frame;
//                        otherwise the parity bit is clocked past and ignored.
// ============================================================================
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_AW        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_scan_code,
  output logic       rx_data_ready,
  input  logic       rx_read,
  output logic       rx_overflow,
  output logic       rx_frame_err
);

  localparam int C_FW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int C_TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int C_DEPTH = 2 ** FIFO_AW;

  localparam logic [C_FW-1:0]    C_FILT_LAST = C_FW'(FILTER_LEN - 1);
  localparam logic [C_TW-1:0]    C_TO_LIMIT  = C_TW'(TIMEOUT_CYCLES);
  localparam logic [C_TW-1:0]    C_TO_ONE    = C_TW'(1);
  localparam logic [FIFO_AW:0]   C_CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   C_CNT_FULL  = (FIFO_AW + 1)'(C_DEPTH);
  localparam logic [FIFO_AW-1:0] C_PTR_ONE   = FIFO_AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronisers (idle level of the bus is high)
  // --------------------------------------------------------------------------
  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk_i;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data_i;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Clock deglitch filter: the filtered level flips only after FILTER_LEN
  // consecutive synchronised samples disagree with it; any agreeing sample
  // restarts the run, so short glitches never reach the FSM.
  // --------------------------------------------------------------------------
  logic            r_clk_filt;
  logic [C_FW-1:0] r_filt_cnt;
  logic            r_strobe;
  logic            w_filt_flip;

  assign w_filt_flip = (r_clk_s2 != r_clk_filt) && (r_filt_cnt == C_FILT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
      r_strobe   <= 1'b0;
    end else begin
      r_strobe <= w_filt_flip && r_clk_filt;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (w_filt_flip) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + C_FW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame timeout counter (saturating)
  // --------------------------------------------------------------------------
  state_t          r_state, w_state_nxt;
  logic [C_TW-1:0] r_to_cnt;
  logic            w_timeout;

  assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == C_TO_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (r_strobe || (r_state == ST_IDLE)) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != C_TO_LIMIT) begin
      r_to_cnt <= r_to_cnt + C_TO_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_push, w_push_set;
  logic       r_err,  w_err_set;
  logic       w_par_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic r_par, w_par_nxt;
  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  assign w_par_ok = ^{r_shift, r_par};
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_push    <= 1'b0;
      r_err     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_push    <= w_push_set;
      r_err     <= w_err_set;
`ifdef PS2_PARITY_CHECK_EN
      r_par     <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_push_set    = 1'b0;
    w_err_set     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    w_par_nxt     = r_par;
`endif
    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
      w_err_set   = 1'b1;
    end else if (r_strobe) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_dat_s2) begin
            w_state_nxt   = ST_DATA;
            w_bit_cnt_nxt = '0;
          end
        end
        ST_DATA: begin
          w_shift_nxt   = {r_dat_s2, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = ST_PARITY;
          end
        end
        ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          w_par_nxt   = r_dat_s2;
`endif
          w_state_nxt = ST_STOP;
        end
        default: begin
          if (r_dat_s2 && w_par_ok) begin
            w_push_set = 1'b1;
          end else begin
            w_err_set  = 1'b1;
          end
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Scan-code FIFO. A pop in the same cycle as a push onto a full FIFO frees
  // the slot first, so the push is accepted without overflow.
  // --------------------------------------------------------------------------
  logic [7:0]         r_mem [C_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_count, w_count_nxt;
  logic [7:0]         r_scan;
  logic               r_ready, r_overflow;
  logic               w_pop, w_full, w_push_ok;

  assign w_pop     = rx_read && (r_count != '0);
  assign w_full    = (r_count == C_CNT_FULL);
  assign w_push_ok = r_push && (!w_full || w_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop) begin
      w_count_nxt = r_count + C_CNT_ONE;
    end else if (!w_push_ok && w_pop) begin
      w_count_nxt = r_count - C_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_scan     <= 8'h00;
      r_ready    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_ready    <= (w_count_nxt != '0);
      r_overflow <= r_push && !w_push_ok;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_scan   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
    end
  end

  assign rx_scan_code  = r_scan;
  assign rx_data_ready = r_ready;
  assign rx_overflow   = r_overflow;
  assign rx_frame_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx_fifo
// Description : Directed self-checking bench for ps2_rx_fifo. Drives PS/2
//               frames bit by bit and checks popped codes, ready flag and
//               error/overflow pulse counts against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk_i = 1'b1;
  logic       ps2_data_i = 1'b1;
  logic       rx_read = 1'b0;
  logic [7:0] rx_scan_code;
  logic       rx_data_ready;
  logic       rx_overflow;
  logic       rx_frame_err;

  int n_vec  = 0;
  int n_err  = 0;
  int n_ovf  = 0;
  int n_ferr = 0;
  int half   = 40;
  int base;

  always #10 clk = ~clk;

  ps2_rx_fifo #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (1000),
    .FIFO_AW        (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ps2_clk_i     (ps2_clk_i),
    .ps2_data_i    (ps2_data_i),
    .rx_scan_code  (rx_scan_code),
    .rx_data_ready (rx_data_ready),
    .rx_read       (rx_read),
    .rx_overflow   (rx_overflow),
    .rx_frame_err  (rx_frame_err)
  );

  always @(negedge clk) begin
    if (rx_overflow)  n_ovf  = n_ovf + 1;
    if (rx_frame_err) n_ferr = n_ferr + 1;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Sends bits [0..nbits-1] of a frame; glitch_bit >= 0 pulses ps2_clk low
  // for 3 cycles in the middle of that bit's high phase.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      ps2_data_i = bits[i];
      if (i == glitch_bit) begin
        cyc(half / 2);
        ps2_clk_i = 1'b0;
        cyc(3);
        ps2_clk_i = 1'b1;
        cyc(half / 2);
      end else begin
        cyc(half);
      end
      ps2_clk_i = 1'b0;
      cyc(half);
      ps2_clk_i = 1'b1;
    end
    cyc(half / 2);
    ps2_data_i = 1'b1;
    cyc(half / 2 + 20);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_good,
                            input logic stop, input int glitch_bit);
    logic par;
    par = par_good ? ~^d : ^d;
    send_bits({stop, par, d, 1'b0}, 11, glitch_bit);
  endtask

  task automatic pop(input string tag, input logic [7:0] exp_code, input logic exp_rdy);
    @(posedge clk);
    #1 rx_read = 1'b1;
    @(posedge clk);
    #1 rx_read = 1'b0;
    chk({tag, "_code"}, rx_scan_code, exp_code);
    chk({tag, "_rdy"}, {7'd0, rx_data_ready}, {7'd0, exp_rdy});
  endtask

  initial begin
    cyc(5);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_code", rx_scan_code, 8'h00);
    chk("rst_rdy", {7'd0, rx_data_ready}, 8'h00);
    chk("rst_ovf", {7'd0, rx_overflow}, 8'h00);
    chk("rst_ferr", {7'd0, rx_frame_err}, 8'h00);

    // Single 0x1C frame at 2 us half period
    half = 100;
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    chk("t1_rdy", {7'd0, rx_data_ready}, 8'h01);
    chk("t1_ferr", n_ferr[7:0], 8'd0);
    pop("t1_pop", 8'h1C, 1'b0);

    // E0 F0 75 queued, then popped four cycles apart
    half = 40;
    send_frame(8'hE0, 1'b1, 1'b1, -1);
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    send_frame(8'h75, 1'b1, 1'b1, -1);
    pop("t2_pop0", 8'hE0, 1'b1);
    cyc(2);
    pop("t2_pop1", 8'hF0, 1'b1);
    cyc(2);
    pop("t2_pop2", 8'h75, 1'b0);

    // 17 frames into a 16-deep FIFO
    for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b1, 1'b1, -1);
    chk("t3_ovf", n_ovf[7:0], 8'd1);
    for (int i = 1; i <= 16; i++) pop("t3_pop", 8'(i), (i != 16));
    pop("t3_empty", 8'h10, 1'b0);

    // Bad stop bit, then a good frame
    base = n_ferr;
    send_frame(8'h1C, 1'b1, 1'b0, -1);
    chk("t4_ferr", 8'(n_ferr - base), 8'd1);
    chk("t4_rdy", {7'd0, rx_data_ready}, 8'h00);
    send_frame(8'h1A, 1'b1, 1'b1, -1);
    pop("t4_pop", 8'h1A, 1'b0);

    // Frame abandoned after four data bits
    base = n_ferr;
    send_bits({1'b1, 1'b1, 8'h0F, 1'b0}, 5, -1);
    cyc(1500);
    chk("t5_ferr", 8'(n_ferr - base), 8'd1);
    chk("t5_rdy", {7'd0, rx_data_ready}, 8'h00);
    send_frame(8'h29, 1'b1, 1'b1, -1);
    pop("t5_pop", 8'h29, 1'b0);

    // Clock glitch mid-frame is filtered out
    send_frame(8'h5A, 1'b1, 1'b1, 5);
    pop("t6_glitch", 8'h5A, 1'b0);

    // Parity error handling
    base = n_ferr;
    send_frame(8'hF0, 1'b0, 1'b1, -1);
`ifdef PS2_PARITY_CHECK_EN
    chk("t6_par_ferr", 8'(n_ferr - base), 8'd1);
    chk("t6_par_rdy", {7'd0, rx_data_ready}, 8'h00);
`else
    chk("t6_par_ferr", 8'(n_ferr - base), 8'd0);
    pop("t6_par_pop", 8'hF0, 1'b0);
`endif
    chk("end_ovf", n_ovf[7:0], 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
